// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3). Converts an N-bit unsigned
// value into DIGITS packed BCD digits over N clock cycles; start/busy/done handshake.
module bin2bcd_seq #(
    parameter int N      = 9,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [N-1:0]          bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    // Handshake: start is accepted only in IDLE; busy is high from the accepting
    // edge to the edge of the N-th shift; done pulses for exactly one cycle after that.
    logic [0:0]            state;
    logic [N-1:0]          bin_sr;
    logic [4*DIGITS-1:0]   bcd_sr;
    logic [CW-1:0]         cnt;

    logic [4*DIGITS-1:0]   corr;
    logic [4*DIGITS+N-1:0] shifted;

    // Digits are <=9 before correction, so the +3 never leaves the 4-bit digit.
    always_comb begin
        corr = bcd_sr;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_sr[4*k +: 4] >= 4'd5) begin
                corr[4*k +: 4] = bcd_sr[4*k +: 4] + 4'd3;
            end
        end
        shifted = {corr, bin_sr} << 1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            bin_sr  <= '0;
            bcd_sr  <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        bin_sr <= bin_in;
                        bcd_sr <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_sr <= shifted[4*DIGITS+N-1:N];
                    bin_sr <= shifted[N-1:0];
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        bcd_out <= shifted[4*DIGITS+N-1:N];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter ("shift-add-3" / double dabble) placed directly downstream of the parameterised binary adder.
- Accepts the adder result as {Cout, Sum} and converts it over N clock cycles into packed BCD digits for the seven-segment display stage.
- One conversion in flight at a time, with a start/busy/done handshake.

Parameters:
- N, 9, binary input width. Default covers the 8-bit adder result plus its carry, max 511.
- DIGITS, 3, number of BCD output digits. A legal configuration requires 10^DIGITS > 2^N - 1. Illegal configurations are unsupported and are not exercised.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request a conversion; sampled only when idle
- bin_in  input  N  unsigned binary value, sampled on the accepting edge; from the adder, {Cout, Sum}
- busy  output  1  high while a conversion is in progress
- done  output  1  single-cycle pulse when bcd_out has just been updated
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (ones) in [3:0], digit k in [4k+3:4k]

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on rst_n. No asynchronous paths.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, busy=0, done=0, bcd_out=0.
  - Internal shift register and counter are cleared.
  - Reset overrides start.
- Internal storage:
  - bin_sr: N-bit shift register.
  - bcd_sr: 4*DIGITS-bit scratch register.
  - cnt: counter of width ceil(log2(N+1)).
- States: IDLE, SHIFT. All outputs are registered.
- IDLE:
  - If start=1 at edge E0: bin_sr<=bin_in, bcd_sr<=0, cnt<=0, busy<=1, state<=SHIFT.
  - Otherwise hold everything.
  - done<=0 on every IDLE edge, so done lasts exactly one cycle.
- SHIFT, each edge:
  - First, every 4-bit digit of bcd_sr that is >=5 gets +3, computed combinationally in the same cycle, independently per digit.
  - Then {bcd_sr, bin_sr} is shifted left by 1: MSB of bin_sr enters bit 0 of bcd_sr, and bit 0 of bin_sr is filled with 0.
  - cnt<=cnt+1.
- Completion:
  - On the edge where the N-th shift occurs (edge E_N), the corrected-and-shifted value is written into bcd_out.
  - On that same edge: done<=1, busy<=0, state<=IDLE.
- Latency and throughput:
  - busy is high from E0 to E_N, i.e. N cycles.
  - done is high for the single cycle between E_N and E_N+1.
  - The earliest next accept is E_N+1. With start held high, conversions repeat every N+1 cycles.
- start while busy: ignored. bin_in changes while busy have no effect, because the value is captured at E0.
- bcd_out:
  - Holds its previous result throughout a conversion.
  - Changes only at completion or on reset.
- Reset mid-conversion: aborts immediately. No done pulse; bcd_out=0; returns to IDLE.
- Width rules:
  - The add-3 step is 4-bit and never overflows a digit, because the digit is <=9 before correction.
  - The carry out of the top digit is guaranteed 0 by the DIGITS legality rule.
- Zero input: performs the full N cycles and produces all-zero digits with a done pulse. There is no early termination.

Test Plan:
1. Reset, then bin_in=9'd511 (adder 8'hFF + 8'hFF + Cin=1), start pulse 1 cycle -> busy for 9 cycles; at E9, done=1 for 1 cycle and bcd_out=12'h511; busy=0.
2. bin_in=9'd0, start -> done after 9 cycles; bcd_out=12'h000. Then bin_in=9'd255 -> bcd_out=12'h255. Check that bcd_out holds 12'h000 during the second conversion.
3. start held high, bin_in fixed at 9'd100 -> done pulses every 10 cycles; bcd_out=12'h100 each time; busy low exactly 1 cycle between conversions.
4. Start conversion of 9'd399; at E3, drive start=1 with bin_in=9'd7 -> ignored; result 12'h399 at E9; no extra done.
5. Start conversion of 9'd42; assert rst_n=0 at E4 for 1 cycle -> busy=0, done never pulses, bcd_out=12'h000. Restart with 9'd42 -> 12'h042.
6. Exhaustive sweep 0..511 via start/done handshake -> each bcd_out decodes to the input value; all digits <=9.
